instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter PC_W, default 6: program-counter width (64-word instruction memory).
REQ-002 Parameter TIMEOUT_CYC, default 15: maximum cycles waiting for imem_ack.
REQ-003 clock  in  1  clock, rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 fetch_start  in  1  single-cycle request to fetch the instruction at pc.
REQ-006 pc_write  in  1  PC update strobe.
REQ-007 pc_sel  in  1  0 = pc+1, 1 = pc+1+sign-extended ir[5:0].
REQ-008 imem_req  out  1  memory read request, level.
REQ-009 imem_addr  out  PC_W  read address, held stable while imem_req is high.
REQ-010 imem_ack  in  1  read data valid this cycle.
REQ-011 imem_rdata  in  16  instruction word.
REQ-012 ir  out  16  instruction register.
REQ-013 opcode_out  out  27  registered decode: [26:25]=RX, [24:23]=RY, [22:0]=one-hot instruction class.
REQ-014 pc  out  PC_W  current program counter.
REQ-015 instr_valid  out  1  ir/opcode_out hold a freshly fetched word.
REQ-016 fetch_busy  out  1  high in REQ state.
REQ-017 fetch_err  out  1  sticky timeout flag (FETCH_TIMEOUT_EN only; otherwise tied 0).

Function
REQ-018 The FSM SHALL have states IDLE, REQ, HOLD.
- IDLE --fetch_start--> REQ.
- REQ --imem_ack--> HOLD.
- HOLD --fetch_start--> REQ.
REQ-019 On entry to REQ: imem_addr latched from pc; imem_req high from the next cycle until the cycle imem_ack is sampled high.
REQ-020 On ack: ir <= imem_rdata and opcode_out <= decode(imem_rdata) on the same edge; instr_valid high from the next cycle until the next fetch_start.
REQ-021 Decode: opcode = ir[15:12], RX = ir[11:10], RY = ir[9:8].
- Index 0 = NOOP (0000).
- Indices 1-4 = opcode 0001 selected by ir[9:8].
- Opcodes 0010..1011 map to indices 5..14.
- 1100 maps to 15/16 by ir[8].
- 1101 maps to 17; 1110 maps to 18.
- 1111 maps to 19..22 by ir[9:8].
- opcode_out[22:0] is exactly one-hot for every input word.
REQ-022 On pc_write: pc <= pc+1 or pc+1+sext(ir[5:0]) per pc_sel, modulo 2^PC_W. Example: pc 63, +1 -> 0.
REQ-023 fetch_start while in REQ SHALL be ignored.
REQ-024 pc_write while in REQ SHALL update pc without changing the latched imem_addr.
REQ-025 imem_ack outside REQ SHALL be ignored.
REQ-026 fetch_start and pc_write in the same cycle: pc updates, and the fetch uses the old pc.

Reset
REQ-027 Reset SHALL immediately set: state IDLE, pc 0, imem_req 0, imem_addr 0, ir 0.
REQ-028 Reset SHALL set opcode_out = 27'h1 (NOOP), instr_valid 0, fetch_busy 0, fetch_err 0.
REQ-029 Reset during REQ SHALL abort the fetch; a late imem_ack after release SHALL be ignored.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined:
- A counter runs in REQ.
- If no ack arrives after TIMEOUT_CYC cycles in REQ, the block sets fetch_err, drops imem_req, loads ir 0 and opcode_out NOOP, and enters HOLD.
REQ-031 Macro FETCH_TIMEOUT_EN undefined: REQ waits indefinitely and fetch_err is constant 0.

Structure
REQ-032 A shared package SHALL hold the 4-bit opcode constants, the 23 one-hot class indices (0..22) and the FSM state encoding.
REQ-033 Decode logic SHALL be a sub-module instr_decode: combinational, 16 bits in, 27 bits out, reusable by the bench.

Verification
REQ-034 Reset, then fetch_start with ack 2 cycles later and rdata 16'h4E00 -> opcode_out[7]=1, RX=3, RY=2, instr_valid=1.
REQ-035 pc=10, ir[5:0]=6'b111110, pc_write with pc_sel=1 -> pc=9; pc=63, pc_sel=0 -> pc=0.
REQ-036 Sweep all 65536 rdata values -> opcode_out[22:0] always one-hot and equal to instr_decode output; 16'hF300 -> bit 22.
REQ-037 fetch_start while busy plus spurious ack in IDLE -> single fetch and single ir update.
REQ-038 Reset asserted mid-REQ, ack after release -> ir stays 0, opcode_out 27'h1.
REQ-039 FETCH_TIMEOUT_EN defined, no ack -> fetch_err=1 after 15 REQ cycles, imem_req=0, opcode_out=27'h1.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode values, one-hot
// class indices, decode widths and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int INSTR_W     = 16;
  localparam int NUM_CLASSES = 23;
  localparam int DEC_W       = NUM_CLASSES + 4;

  // Major opcode field ir[15:12]
  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_GRP1 = 4'h1;
  localparam logic [3:0] OP_02   = 4'h2;
  localparam logic [3:0] OP_03   = 4'h3;
  localparam logic [3:0] OP_04   = 4'h4;
  localparam logic [3:0] OP_05   = 4'h5;
  localparam logic [3:0] OP_06   = 4'h6;
  localparam logic [3:0] OP_07   = 4'h7;
  localparam logic [3:0] OP_08   = 4'h8;
  localparam logic [3:0] OP_09   = 4'h9;
  localparam logic [3:0] OP_0A   = 4'hA;
  localparam logic [3:0] OP_0B   = 4'hB;
  localparam logic [3:0] OP_GRPC = 4'hC;
  localparam logic [3:0] OP_0D   = 4'hD;
  localparam logic [3:0] OP_0E   = 4'hE;
  localparam logic [3:0] OP_GRPF = 4'hF;

  // Bit positions in the one-hot class vector opcode_out[22:0]
  localparam int CLS_NOOP = 0;
  localparam int CLS_G1_0 = 1;
  localparam int CLS_G1_1 = 2;
  localparam int CLS_G1_2 = 3;
  localparam int CLS_G1_3 = 4;
  localparam int CLS_OP02 = 5;
  localparam int CLS_OP03 = 6;
  localparam int CLS_OP04 = 7;
  localparam int CLS_OP05 = 8;
  localparam int CLS_OP06 = 9;
  localparam int CLS_OP07 = 10;
  localparam int CLS_OP08 = 11;
  localparam int CLS_OP09 = 12;
  localparam int CLS_OP0A = 13;
  localparam int CLS_OP0B = 14;
  localparam int CLS_GC_0 = 15;
  localparam int CLS_GC_1 = 16;
  localparam int CLS_OP0D = 17;
  localparam int CLS_OP0E = 18;
  localparam int CLS_GF_0 = 19;
  localparam int CLS_GF_1 = 20;
  localparam int CLS_GF_2 = 21;
  localparam int CLS_GF_3 = 22;

  // Decode of an all-zero word: NOOP class, RX = RY = 0
  localparam logic [DEC_W-1:0] DEC_NOOP = 27'h1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_decode.sv
// Combinational instruction decode: 16-bit word in, {RX, RY, one-hot class}
// out. Exactly one class bit is set for every input word.
module instr_decode
  import instr_fetch_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [DEC_W-1:0]   opcode
);

  logic [NUM_CLASSES-1:0] cls;
  logic                   unused_low_bits;

  // The operand/immediate byte carries no decode information.
  assign unused_low_bits = ^instr[7:0];

  always_comb begin
    cls = '0;
    case (instr[15:12])
      OP_NOOP: cls[CLS_NOOP] = 1'b1;
      OP_GRP1: begin
        case (instr[9:8])
          2'd0:    cls[CLS_G1_0] = 1'b1;
          2'd1:    cls[CLS_G1_1] = 1'b1;
          2'd2:    cls[CLS_G1_2] = 1'b1;
          default: cls[CLS_G1_3] = 1'b1;
        endcase
      end
      OP_02:   cls[CLS_OP02] = 1'b1;
      OP_03:   cls[CLS_OP03] = 1'b1;
      OP_04:   cls[CLS_OP04] = 1'b1;
      OP_05:   cls[CLS_OP05] = 1'b1;
      OP_06:   cls[CLS_OP06] = 1'b1;
      OP_07:   cls[CLS_OP07] = 1'b1;
      OP_08:   cls[CLS_OP08] = 1'b1;
      OP_09:   cls[CLS_OP09] = 1'b1;
      OP_0A:   cls[CLS_OP0A] = 1'b1;
      OP_0B:   cls[CLS_OP0B] = 1'b1;
      OP_GRPC: begin
        if (instr[8]) cls[CLS_GC_1] = 1'b1;
        else          cls[CLS_GC_0] = 1'b1;
      end
      OP_0D:   cls[CLS_OP0D] = 1'b1;
      OP_0E:   cls[CLS_OP0E] = 1'b1;
      default: begin
        case (instr[9:8])
          2'd0:    cls[CLS_GF_0] = 1'b1;
          2'd1:    cls[CLS_GF_1] = 1'b1;
          2'd2:    cls[CLS_GF_2] = 1'b1;
          default: cls[CLS_GF_3] = 1'b1;
        endcase
      end
    endcase
    opcode = {instr[11:10], instr[9:8], cls};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD fetch FSM, program counter and
// registered decode. Define FETCH_TIMEOUT_EN to enable the ack timeout.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W        = 6,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic               pc_write,
  input  logic               pc_sel,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [DEC_W-1:0]   opcode_out,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic               fetch_busy,
  output logic               fetch_err,
  output fetch_state_e       dbg_state
);

  // Memory handshake: imem_req is a level held high with imem_addr stable
  // from the first REQ cycle until the cycle imem_ack is sampled high; the
  // word on imem_rdata is taken in that same cycle. imem_ack seen while
  // imem_req is low is ignored.

  localparam int SUM_W = (PC_W > 6) ? PC_W : 6;

  fetch_state_e           state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        addr_q, addr_d;
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic [INSTR_W-1:0]     ir_q, ir_d;
  logic [DEC_W-1:0]       op_q, op_d;
  logic                   valid_q, valid_d;
  logic [DEC_W-1:0]       rdata_dec;
  logic [SUM_W-1:0]       pc_ext, pc_ofs, pc_sum;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   err_q, err_d;
`endif

  instr_decode u_decode (
    .instr  (imem_rdata),
    .opcode (rdata_dec)
  );

  // Relative jump: the 6-bit immediate is sign-extended, then wrapped to PC_W.
  always_comb begin
    pc_ext = SUM_W'(pc_q);
    pc_ofs = pc_sel ? SUM_W'($signed(ir_q[5:0])) : '0;
    pc_sum = pc_ext + SUM_W'(1) + pc_ofs;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    busy_d  = busy_q;
    ir_d    = ir_q;
    op_d    = op_q;
    valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif

    if (pc_write) begin
      pc_d = pc_sum[PC_W-1:0];
    end

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (fetch_start) begin
          state_d = ST_REQ;
          addr_d  = pc_q;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_d = ST_HOLD;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          ir_d    = imem_rdata;
          op_d    = rdata_dec;
          valid_d = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_HOLD;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          ir_d    = '0;
          op_d    = DEC_NOOP;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ir_q    <= '0;
      op_q    <= DEC_NOOP;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign ir          = ir_q;
  assign opcode_out  = op_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign fetch_busy  = busy_q;
  assign dbg_state   = state_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of fetched words,
// PC arithmetic, decode sweep, ignored requests/acks, reset abort, timeout.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int PC_W        = 6;
  localparam int TIMEOUT_CYC = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_start = 1'b0;
  logic              pc_write = 1'b0;
  logic              pc_sel = 1'b0;
  logic              imem_ack = 1'b0;
  logic [15:0]       imem_rdata = 16'h0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       ir;
  logic [26:0]       opcode_out;
  logic [PC_W-1:0]   pc;
  logic              instr_valid;
  logic              fetch_busy;
  logic              fetch_err;
  fetch_state_e      dbg_state;

  logic [15:0]       sweep_word = 16'h0;
  logic [26:0]       sweep_op;

  int                n_checks = 0;
  int                n_fail = 0;
  logic [42:0]       exp_q[$];
  logic [PC_W-1:0]   exp_pc = '0;
  logic [15:0]       last_ir = 16'h0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  instr_fetch_unit #(.PC_W(PC_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .opcode_out  (opcode_out),
    .pc          (pc),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  instr_decode u_ref_decode (
    .instr  (sweep_word),
    .opcode (sweep_op)
  );

  // Reference decode written from the opcode table.
  function automatic logic [26:0] model_decode(input logic [15:0] w);
    int idx;
    int op;
    op = int'(w[15:12]);
    if (op == 0)       idx = 0;
    else if (op == 1)  idx = 1 + int'(w[9:8]);
    else if (op <= 11) idx = op + 3;
    else if (op == 12) idx = 15 + int'(w[8]);
    else if (op == 13) idx = 17;
    else if (op == 14) idx = 18;
    else               idx = 19 + int'(w[9:8]);
    return {w[11:10], w[9:8], 23'(1) << idx};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic collect_result();
    int waited;
    logic [42:0] exp;
    waited = 0;
    while (instr_valid !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    n_checks++;
    if (waited >= 20 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL collect: instr_valid=%b after %0d cycles, queued=%0d, required valid with 1 queued", instr_valid, waited, exp_q.size());
      exp_q.delete();
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (ir !== exp[15:0]) begin n_fail++; $display("FAIL sb_ir: got %h expected %h", ir, exp[15:0]); end
      n_checks++;
      if (opcode_out !== exp[42:16]) begin n_fail++; $display("FAIL sb_opcode: got %h expected %h (word %h)", opcode_out, exp[42:16], exp[15:0]); end
      n_checks++;
      if (imem_req !== 1'b0 || dbg_state !== ST_HOLD) begin n_fail++; $display("FAIL sb_after_ack: req=%b state=%0d expected req=0 state=%0d", imem_req, dbg_state, ST_HOLD); end
    end
  endtask

  task automatic drive_fetch(input logic [15:0] word, input int delay);
    @(negedge clock);
    fetch_start = 1'b1;
    exp_q.push_back({model_decode(word), word});
    @(negedge clock);
    fetch_start = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || fetch_busy !== 1'b1) begin n_fail++; $display("FAIL fetch_req: req=%b busy=%b expected 1 1", imem_req, fetch_busy); end
    n_checks++;
    if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL fetch_addr: got %0d expected %0d", imem_addr, exp_pc); end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_clear: got %b expected 0", instr_valid); end
    repeat (delay) @(negedge clock);
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    last_ir = word;
    collect_result();
  endtask

  task automatic do_pc_write(input logic sel);
    logic [5:0] ofs;
    @(negedge clock);
    pc_write = 1'b1;
    pc_sel = sel;
    ofs = sel ? last_ir[5:0] : 6'd0;
    exp_pc = exp_pc + 6'd1 + ofs;
    @(negedge clock);
    pc_write = 1'b0;
    pc_sel = 1'b0;
    n_checks++;
    if (pc !== exp_pc) begin n_fail++; $display("FAIL pc_write(sel=%b): got %0d expected %0d", sel, pc, exp_pc); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (pc !== 6'd0 || imem_addr !== 6'd0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_pc_addr_req: pc=%0d addr=%0d req=%b expected 0 0 0", pc, imem_addr, imem_req); end
    n_checks++;
    if (ir !== 16'h0 || opcode_out !== 27'h1) begin n_fail++; $display("FAIL reset_ir_op: ir=%h op=%h expected 0000 0000001", ir, opcode_out); end
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_busy !== 1'b0 || fetch_err !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_flags: valid=%b busy=%b err=%b state=%0d expected 0 0 0 0", instr_valid, fetch_busy, fetch_err, dbg_state);
    end
    reset = 1'b0;
    exp_pc = '0;
    last_ir = 16'h0;
    @(negedge clock);
    n_checks++;
    if (dbg_state !== ST_IDLE || imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_release: state=%0d req=%b expected 0 0", dbg_state, imem_req); end
  endtask

  task automatic test_basic();
    drive_fetch(16'h4E00, 1);
    n_checks++;
    if (opcode_out[7] !== 1'b1) begin n_fail++; $display("FAIL basic_class7: got %b expected 1", opcode_out[7]); end
    n_checks++;
    if (opcode_out[26:25] !== 2'd3 || opcode_out[24:23] !== 2'd2) begin n_fail++; $display("FAIL basic_rxry: rx=%0d ry=%0d expected 3 2", opcode_out[26:25], opcode_out[24:23]); end
    n_checks++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", instr_valid); end
    repeat (3) @(negedge clock);
    n_checks++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_hold: got %b expected 1", instr_valid); end
  endtask

  task automatic test_decode_table();
    logic [15:0] words [16];
    words = '{16'h0000, 16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h2000, 16'h7C55, 16'hB000,
              16'hC000, 16'hC100, 16'hDFFF, 16'hE400, 16'hF000, 16'hF100, 16'hF200, 16'hF300};
    for (int i = 0; i < 16; i++) drive_fetch(words[i], $urandom_range(0, 3));
    for (int i = 0; i < 8; i++) drive_fetch(16'($urandom), $urandom_range(0, 4));
  endtask

  task automatic test_decode_sweep();
    for (int i = 0; i < 65536; i++) begin
      sweep_word = 16'(i);
      #1;
      n_checks++;
      if (sweep_op !== model_decode(sweep_word)) begin n_fail++; $display("FAIL sweep_decode: word %h got %h expected %h", sweep_word, sweep_op, model_decode(sweep_word)); end
      n_checks++;
      if (!$onehot(sweep_op[22:0])) begin n_fail++; $display("FAIL sweep_onehot: word %h class %h not one-hot", sweep_word, sweep_op[22:0]); end
    end
    sweep_word = 16'hF300;
    #1;
    n_checks++;
    if (sweep_op[22] !== 1'b1) begin n_fail++; $display("FAIL sweep_f300: bit22=%b expected 1", sweep_op[22]); end
    @(negedge clock);
  endtask

  task automatic test_pc_update();
    drive_fetch(16'h003E, 0);
    for (int i = 0; i < 64 && exp_pc != 6'd10; i++) do_pc_write(1'b0);
    do_pc_write(1'b1);
    n_checks++;
    if (pc !== 6'd9) begin n_fail++; $display("FAIL pc_neg_offset: got %0d expected 9", pc); end
    for (int i = 0; i < 64 && exp_pc != 6'd63; i++) do_pc_write(1'b0);
    do_pc_write(1'b0);
    n_checks++;
    if (pc !== 6'd0) begin n_fail++; $display("FAIL pc_wrap: got %0d expected 0", pc); end
    drive_fetch(16'h0005, 2);
    do_pc_write(1'b1);
    n_checks++;
    if (pc !== 6'd6) begin n_fail++; $display("FAIL pc_pos_offset: got %0d expected 6", pc); end
  endtask

  task automatic test_pc_during_req();
    logic [PC_W-1:0] old_pc;
    logic [15:0] word;
    word = 16'h2345;
    old_pc = exp_pc;
    @(negedge clock);
    fetch_start = 1'b1;
    pc_write = 1'b1;
    pc_sel = 1'b0;
    exp_pc = exp_pc + 6'd1;
    exp_q.push_back({model_decode(word), word});
    @(negedge clock);
    fetch_start = 1'b0;
    n_checks++;
    if (imem_addr !== old_pc || pc !== exp_pc) begin n_fail++; $display("FAIL same_cycle: addr=%0d pc=%0d expected %0d %0d", imem_addr, pc, old_pc, exp_pc); end
    exp_pc = exp_pc + 6'd1;
    @(negedge clock);
    pc_write = 1'b0;
    n_checks++;
    if (imem_addr !== old_pc || pc !== exp_pc || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL pc_in_req: addr=%0d pc=%0d req=%b expected %0d %0d 1", imem_addr, pc, imem_req, old_pc, exp_pc);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ack = 1'b0;
    last_ir = word;
    collect_result();
  endtask

  task automatic test_busy_and_spurious();
    logic [15:0] word;
    @(negedge clock);
    imem_ack = 1'b1;
    imem_rdata = 16'hF300;
    @(negedge clock);
    imem_ack = 1'b0;
    n_checks++;
    if (ir !== last_ir || dbg_state !== ST_HOLD || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL spurious_hold: ir=%h state=%0d req=%b expected %h %0d 0", ir, dbg_state, imem_req, last_ir, ST_HOLD);
    end
    word = 16'hD0A5;
    @(negedge clock);
    fetch_start = 1'b1;
    exp_q.push_back({model_decode(word), word});
    @(negedge clock);
    @(negedge clock);
    fetch_start = 1'b0;
    n_checks++;
    if (imem_addr !== exp_pc || dbg_state !== ST_REQ || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL busy_ignore: addr=%0d state=%0d req=%b expected %0d %0d 1", imem_addr, dbg_state, imem_req, exp_pc, ST_REQ);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ack = 1'b0;
    last_ir = word;
    collect_result();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_checks++;
      if (imem_req !== 1'b0 || dbg_state !== ST_HOLD || ir !== word) begin
        n_fail++; $display("FAIL single_fetch: cycle %0d req=%b state=%0d ir=%h expected 0 %0d %h", i, imem_req, dbg_state, ir, ST_HOLD, word);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
`ifdef FETCH_TIMEOUT_EN
    @(negedge clock);
    fetch_start = 1'b1;
    @(negedge clock);
    fetch_start = 1'b0;
    cnt = 0;
    while (imem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clock);
    end
    n_checks++;
    if (cnt != TIMEOUT_CYC) begin n_fail++; $display("FAIL timeout_cycles: req high %0d cycles expected %0d", cnt, TIMEOUT_CYC); end
    n_checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || opcode_out !== 27'h1 || ir !== 16'h0) begin
      n_fail++; $display("FAIL timeout_state: err=%b req=%b op=%h ir=%h expected 1 0 0000001 0000", fetch_err, imem_req, opcode_out, ir);
    end
    last_ir = 16'h0;
    drive_fetch(16'h3A11, 1);
    n_checks++;
    if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: err=%b expected 1", fetch_err); end
`else
    logic [15:0] word;
    word = 16'h8123;
    @(negedge clock);
    fetch_start = 1'b1;
    exp_q.push_back({model_decode(word), word});
    @(negedge clock);
    fetch_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (imem_req === 1'b1 && fetch_err === 1'b0) cnt++;
      @(negedge clock);
    end
    n_checks++;
    if (cnt != 25) begin n_fail++; $display("FAIL no_timeout: req held %0d of 25 cycles, err=%b expected 25 0", cnt, fetch_err); end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ack = 1'b0;
    last_ir = word;
    collect_result();
`endif
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    fetch_start = 1'b1;
    @(negedge clock);
    fetch_start = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL abort_pre: req=%b expected 1", imem_req); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || dbg_state !== ST_IDLE || pc !== 6'd0) begin
      n_fail++; $display("FAIL abort_async: req=%b busy=%b state=%0d pc=%0d expected 0 0 0 0", imem_req, fetch_busy, dbg_state, pc);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_pc = '0;
    last_ir = 16'h0;
    @(negedge clock);
    imem_ack = 1'b1;
    imem_rdata = 16'h4E00;
    @(negedge clock);
    imem_ack = 1'b0;
    @(negedge clock);
    n_checks++;
    if (ir !== 16'h0 || opcode_out !== 27'h1 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL late_ack: ir=%h op=%h valid=%b expected 0000 0000001 0", ir, opcode_out, instr_valid);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE || imem_req !== 1'b0) begin n_fail++; $display("FAIL late_ack_state: state=%0d req=%b expected 0 0", dbg_state, imem_req); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_decode_table();
    test_decode_sweep();
    test_pc_update();
    test_pc_during_req();
    test_busy_and_spurious();
    test_timeout();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
